// File: rtl/mem_stage_unit_if.sv
// Data-memory request/acknowledge bus.
//   master : drives dmem_req/dmem_we/dmem_addr/dmem_wdata, receives dmem_ack/dmem_rdata
//   slave  : the memory side of the same bus
// dmem_ack is a one-cycle pulse; dmem_rdata is valid only while dmem_ack is high.
interface mem_stage_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM-stage access unit sitting between the EX/MEM and MEM/WB registers.
// Loads (MEMm2reg) and stores (MEMwmem) are issued on a registered req/ack
// bus; the upstream pipeline is stalled until the access finishes. Non-memory
// instructions pass straight through in the same cycle.
// Ports:
//   clk, clrn        clock (rising edge), asynchronous active-low reset
//   MEMwreg..MEMstoreData  instruction fields from EX/MEM
//   dmem             data-memory bus (master side)
//   mem_stall        holds PC, IF/ID, ID/EX and EX/MEM
//   out*             fields presented to MEM/WB (outMemOut = load data buffer)
//   mem_err          sticky misalignment/timeout flag, cleared only by reset
module mem_stage_unit #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    MEMwreg,
    input  logic                    MEMm2reg,
    input  logic                    MEMwmem,
    input  logic [4:0]              MEMwn,
    input  logic [31:0]             MEMaluResult,
    input  logic [31:0]             MEMstoreData,
    mem_stage_unit_if.master        dmem,
    output logic                    mem_stall,
    output logic                    outWreg,
    output logic                    outM2reg,
    output logic [4:0]              outWn,
    output logic [31:0]             outAluResult,
    output logic [31:0]             outMemOut,
    output logic                    mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 32'd1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tflag_q, tflag_d;

    logic        acc_s;
    logic        mis_s;
    logic        stall_s;

    // Classify the instruction currently held in EX/MEM.
    always_comb begin
        acc_s = MEMm2reg | MEMwmem;
        mis_s = acc_s & (MEMaluResult[1:0] != 2'b00);
    end

    // Next-state, bus, buffer and error-flag logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tflag_d = tflag_q;
        stall_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mis_s) begin
                    // Misaligned: no bus traffic, writeback suppressed below.
                    err_d = 1'b1;
                end else if (acc_s) begin
                    stall_s = 1'b1;
                    req_d   = 1'b1;
                    we_d    = MEMwmem;
                    addr_d  = MEMaluResult;
                    wdata_d = MEMstoreData;
                    cnt_d   = 8'd0;
                    state_d = S_REQ;
                end else begin
                    stall_s = 1'b0;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    if (!we_q) begin
                        buf_d = dmem.dmem_rdata;
                    end else begin
                        buf_d = buf_q;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the access; zero the buffer so no stale data is forwarded.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    buf_d   = 32'd0;
                    tflag_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // MEM/WB captures at this edge; EX/MEM advances too.
                tflag_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                tflag_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            buf_q   <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
        end
    end

    // Output drive; write enable is gated so a stalled, misaligned or
    // timed-out instruction never writes back.
    always_comb begin
        dmem.dmem_req   = req_q;
        dmem.dmem_we    = we_q;
        dmem.dmem_addr  = addr_q;
        dmem.dmem_wdata = wdata_q;
        mem_stall       = stall_s;
        outWreg         = MEMwreg & ~stall_s & ~mis_s
                          & ~((state_q == S_DONE) & tflag_q);
        outM2reg        = MEMm2reg;
        outWn           = MEMwn;
        outAluResult    = MEMaluResult;
        outMemOut       = buf_q;
        mem_err         = err_q;
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: ALU pass-through, load with delayed ack,
// store with immediate ack, ack timeout, misaligned load, reset during REQ.
module tb_mem_stage_unit;

    logic        clk;
    logic        clrn;
    logic        MEMwreg;
    logic        MEMm2reg;
    logic        MEMwmem;
    logic [4:0]  MEMwn;
    logic [31:0] MEMaluResult;
    logic [31:0] MEMstoreData;
    logic        mem_stall;
    logic        outWreg;
    logic        outM2reg;
    logic [4:0]  outWn;
    logic [31:0] outAluResult;
    logic [31:0] outMemOut;
    logic        mem_err;

    int total_cnt;
    int bad_cnt;

    mem_stage_unit_if bus ();

    mem_stage_unit #(.ACK_TIMEOUT(15)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwmem      (MEMwmem),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMstoreData (MEMstoreData),
        .dmem         (bus),
        .mem_stall    (mem_stall),
        .outWreg      (outWreg),
        .outM2reg     (outM2reg),
        .outWn        (outWn),
        .outAluResult (outAluResult),
        .outMemOut    (outMemOut),
        .mem_err      (mem_err)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic m2, input logic wm,
                         input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] sd);
        MEMwreg      = wr;
        MEMm2reg     = m2;
        MEMwmem      = wm;
        MEMwn        = wn;
        MEMaluResult = alu;
        MEMstoreData = sd;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        clrn      = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("rst_we",    {31'd0, bus.dmem_we},  32'd0);
        check("rst_addr",  bus.dmem_addr,         32'd0);
        check("rst_wdata", bus.dmem_wdata,        32'd0);
        check("rst_buf",   outMemOut,             32'd0);
        check("rst_err",   {31'd0, mem_err},      32'd0);
        check("rst_stall", {31'd0, mem_stall},    32'd0);

        // 1. ALU pass-through
        tick();
        clrn = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
        @(negedge clk);
        check("alu_wreg",  {31'd0, outWreg},   32'd1);
        check("alu_wn",    {27'd0, outWn},     32'd5);
        check("alu_res",   outAluResult,       32'h0000_1234);
        check("alu_stall", {31'd0, mem_stall}, 32'd0);
        check("alu_req",   {31'd0, bus.dmem_req}, 32'd0);
        tick();
        @(negedge clk);
        check("alu_req2",  {31'd0, bus.dmem_req}, 32'd0);

        // 2. Load at 0x40, ack in second REQ cycle
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0040, 32'd0);
        @(negedge clk);
        check("ld_idle_stall", {31'd0, mem_stall},    32'd1);
        check("ld_idle_wreg",  {31'd0, outWreg},      32'd0);
        check("ld_idle_req",   {31'd0, bus.dmem_req}, 32'd0);
        tick();
        @(negedge clk);
        check("ld_req1_req",   {31'd0, bus.dmem_req}, 32'd1);
        check("ld_req1_we",    {31'd0, bus.dmem_we},  32'd0);
        check("ld_req1_addr",  bus.dmem_addr,         32'h0000_0040);
        check("ld_req1_stall", {31'd0, mem_stall},    32'd1);
        check("ld_req1_wreg",  {31'd0, outWreg},      32'd0);
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("ld_req2_req",   {31'd0, bus.dmem_req}, 32'd1);
        check("ld_req2_stall", {31'd0, mem_stall},    32'd1);
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        @(negedge clk);
        check("ld_done_stall", {31'd0, mem_stall},    32'd0);
        check("ld_done_wreg",  {31'd0, outWreg},      32'd1);
        check("ld_done_data",  outMemOut,             32'hCAFE_F00D);
        check("ld_done_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("ld_done_m2reg", {31'd0, outM2reg},     32'd1);
        check("ld_done_wn",    {27'd0, outWn},        32'd7);

        // 3. Store at 0x80 back-to-back, immediate ack
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0080, 32'h55AA_55AA);
        @(negedge clk);
        check("st_idle_stall", {31'd0, mem_stall},    32'd1);
        check("st_idle_req",   {31'd0, bus.dmem_req}, 32'd0);
        tick();
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check("st_req_req",    {31'd0, bus.dmem_req}, 32'd1);
        check("st_req_we",     {31'd0, bus.dmem_we},  32'd1);
        check("st_req_addr",   bus.dmem_addr,         32'h0000_0080);
        check("st_req_wdata",  bus.dmem_wdata,        32'h55AA_55AA);
        check("st_req_stall",  {31'd0, mem_stall},    32'd1);
        tick();
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("st_done_stall", {31'd0, mem_stall},    32'd0);
        check("st_done_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("st_done_buf",   outMemOut,             32'hCAFE_F00D);

        // Stray ack in IDLE is ignored
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stray_req", {31'd0, bus.dmem_req}, 32'd0);
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        @(negedge clk);
        check("stray_buf", outMemOut, 32'hCAFE_F00D);

        // 4. Load with no ack -> timeout after 15 REQ cycles
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0100, 32'd0);
        @(negedge clk);
        check("to_idle_stall", {31'd0, mem_stall}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            @(negedge clk);
            check("to_req_req",   {31'd0, bus.dmem_req}, 32'd1);
            check("to_req_addr",  bus.dmem_addr,         32'h0000_0100);
            check("to_req_stall", {31'd0, mem_stall},    32'd1);
            check("to_req_err",   {31'd0, mem_err},      32'd0);
        end
        tick();
        @(negedge clk);
        check("to_done_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("to_done_err",   {31'd0, mem_err},      32'd1);
        check("to_done_wreg",  {31'd0, outWreg},      32'd0);
        check("to_done_buf",   outMemOut,             32'd0);
        check("to_done_stall", {31'd0, mem_stall},    32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_0008, 32'd0);
        @(negedge clk);
        check("to_sticky_err", {31'd0, mem_err}, 32'd1);
        check("to_after_wreg", {31'd0, outWreg}, 32'd1);

        // Reset clears the sticky error
        tick();
        clrn = 1'b0;
        @(negedge clk);
        check("rst2_err", {31'd0, mem_err}, 32'd0);

        // 5. Misaligned load at 0x41
        tick();
        clrn = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_0041, 32'd0);
        @(negedge clk);
        check("mis_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("mis_stall", {31'd0, mem_stall},    32'd0);
        check("mis_wreg",  {31'd0, outWreg},      32'd0);
        check("mis_err0",  {31'd0, mem_err},      32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd6, 32'h0000_0044, 32'd0);
        @(negedge clk);
        check("mis_err1",  {31'd0, mem_err},      32'd1);
        check("mis_req2",  {31'd0, bus.dmem_req}, 32'd0);

        // 6. Reset during REQ cycle 3
        tick();
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0020, 32'd0);
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        @(negedge clk);
        check("r6_prefill", outMemOut, 32'h1234_5678);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0024, 32'd0);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("r6_req3", {31'd0, bus.dmem_req}, 32'd1);
        #2;
        clrn = 1'b0;
        #1;
        check("r6_req_drop", {31'd0, bus.dmem_req}, 32'd0);
        check("r6_addr",     bus.dmem_addr,         32'd0);
        check("r6_buf",      outMemOut,             32'd0);
        check("r6_err",      {31'd0, mem_err},      32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        clrn           = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check("r6_stray_req",   {31'd0, bus.dmem_req}, 32'd0);
        check("r6_stray_stall", {31'd0, mem_stall},    32'd0);
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        @(negedge clk);
        check("r6_stray_buf",  outMemOut,             32'd0);
        check("r6_stray_req2", {31'd0, bus.dmem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
